// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the
// write-back cache slice.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESP
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/dirty/tag/data arrays,
// combinational read, synchronous write.
module cache_line_store #(
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // line status bits, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // tag and data payload, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_wb.sv
// cache_wb: direct-mapped write-back write-allocate
// cache, one word per line, with hit/miss counters.
module cache_wb
  import cache_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_q;
  logic [CNT_W-1:0]  hit_q;
  logic [CNT_W-1:0]  miss_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               hit;
  logic               wr_en;
  logic               wr_dirty;
  logic [DATA_W-1:0]  wr_data;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = line_valid && (line_tag == tag);

  cache_line_store #(
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (req_valid) state_d = LOOKUP;
      LOOKUP:
        if (hit)
          state_d = RESP;
        else if (line_valid && line_dirty)
          state_d = WRITEBACK;
        else
          state_d = REFILL;
      WRITEBACK:
        if (mem_ready) state_d = REFILL;
      REFILL:
        if (mem_ready) state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // handshake and memory-side outputs
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      WRITEBACK: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx};
        mem_wdata = line_data;
      end
      REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // line update: write hit, or refill merged with write
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = wdata_q;
    wr_dirty = 1'b1;
    case (state_q)
      LOOKUP:
        wr_en = hit && (we_q == REQ_WRITE);
      REFILL: begin
        wr_en    = mem_ready;
        wr_dirty = (we_q == REQ_WRITE);
        if (we_q == REQ_READ) wr_data = mem_rdata;
      end
      default: ;
    endcase
  end

  // request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= REQ_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // response word: line data on hit, final word on refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else if (state_q == LOOKUP && hit) begin
      rsp_q <= (we_q == REQ_WRITE) ? wdata_q : line_data;
    end else if (state_q == REFILL && mem_ready) begin
      rsp_q <= wr_data;
    end
  end

  // saturating hit/miss statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_q  <= sat_inc(hit_q);
      else     miss_q <= sat_inc(miss_q);
    end
  end

  assign rsp_rdata = rsp_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_cache_wb.sv
// tb_cache_wb: directed table, corner sequences and
// randomized traffic against a word-level memory model.
module tb_cache_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  cache_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          hit;
    bit          wb;
    logic [11:0] wba;
    logic [31:0] wbd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int rsp_pulses = 0;
  int n_req = 0;
  int mem_lat = 1;
  int wait_cnt = 0;
  bit spur = 1'b0;
  logic [44:0] cap;
  op_t ops[$];

  logic [31:0] ram    [4096];
  logic [31:0] golden [4096];
  logic [11:0] mres   [64];
  bit          mval   [64];
  bit          mdirty [64];
  logic [15:0] exp_hc = '0;
  logic [15:0] exp_mc = '0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // response pulse monitor
  always @(negedge clk) if (rsp_valid) rsp_pulses++;

  // backing store with programmable latency
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_valid) begin
      if (wait_cnt == 0) begin
        cap = {mem_we, mem_addr, mem_wdata};
      end else begin
        chk("mem_stable",
            {mem_we, mem_addr, mem_wdata}, cap);
        chk("req_ready_busy", req_ready, 0);
      end
      if (wait_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
          ops.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = ram[mem_addr];
          ops.push_back({1'b0, mem_addr, 32'h0});
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spur && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic do_req(input logic we,
                        input logic [11:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output int lat,
                        output int mvk);
    int k;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    k = 1;
    mvk = 0;
    while (!rsp_valid && k < 200) begin
      if (mem_valid && mvk == 0) mvk = k;
      @(negedge clk);
      k++;
    end
    rd  = rsp_rdata;
    lat = rsp_valid ? k : -1;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  task automatic run_check(input string nm,
                           input logic we,
                           input logic [11:0] a,
                           input logic [31:0] wd,
                           input logic [31:0] erd,
                           input bit ehit,
                           input bit ewb,
                           input logic [11:0] wba,
                           input logic [31:0] wbd);
    logic [31:0] rd;
    int lat, mvk, nops;
    ops.delete();
    do_req(we, a, wd, rd, lat, mvk);
    n_req++;
    if (ehit) exp_hc = sat(exp_hc);
    else      exp_mc = sat(exp_mc);
    chk({nm, "_rdata"}, rd, erd);
    if (ehit) begin
      chk({nm, "_hit_lat"}, lat, 2);
      chk({nm, "_hit_nomem"}, mvk, 0);
    end else begin
      chk({nm, "_miss_done"}, lat > 2, 1);
      chk({nm, "_miss_mv"}, mvk, 2);
    end
    nops = ehit ? 0 : (ewb ? 2 : 1);
    chk({nm, "_nops"}, ops.size(), nops);
    if (nops > 0 && ops.size() == nops) begin
      if (ewb)
        chk({nm, "_wb"}, ops[0], {1'b1, wba, wbd});
      chk({nm, "_rf"}, ops[nops-1],
          {1'b0, a, 32'h0});
    end
    chk({nm, "_hit_cnt"}, hit_cnt, exp_hc);
    chk({nm, "_miss_cnt"}, miss_cnt, exp_mc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_hc = '0;
    exp_mc = '0;
    for (int i = 0; i < 64; i++) begin
      mval[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) golden[i] = ram[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int k, p0;
    logic [5:0] ri, rt;
    logic [11:0] a, wba;
    logic [31:0] wd, erd, wbd;
    logic we;
    bit h, wb;

    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    ram[12'h040] = 32'hDEADBEEF;
    ram[12'h045] = 32'h0BADF00D;
    ram[12'h080] = 32'h80808080;
    ram[12'h1C0] = 32'h11C011C0;
    ram[12'h0FF] = 32'h0FF0FF00;

    vt[0] = '{0, 12'h040, 0, 32'hDEADBEEF, 0, 0, 0, 0};
    vt[1] = '{0, 12'h040, 0, 32'hDEADBEEF, 1, 0, 0, 0};
    vt[2] = '{1, 12'h005, 32'h12345678,
              32'h12345678, 0, 0, 0, 0};
    vt[3] = '{0, 12'h005, 0, 32'h12345678, 1, 0, 0, 0};
    vt[4] = '{0, 12'h045, 0, 32'h0BADF00D, 0, 1,
              12'h005, 32'h12345678};
    vt[5] = '{0, 12'h005, 0, 32'h12345678, 0, 0, 0, 0};
    vt[6] = '{1, 12'h040, 32'hAAAA5555,
              32'hAAAA5555, 1, 0, 0, 0};
    vt[7] = '{0, 12'h080, 0, 32'h80808080, 0, 1,
              12'h040, 32'hAAAA5555};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vt[i].we,
                vt[i].addr, vt[i].wd, vt[i].rd,
                vt[i].hit, vt[i].wb, vt[i].wba,
                vt[i].wbd);

    // slow refill with a request dropped mid-miss
    mem_lat = 5;
    p0 = rsp_pulses;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'h1C0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("slow_mv", mem_valid, 1);
    @(negedge clk);
    chk("slow_ready_low", req_ready, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 12'h0FF;
    req_wdata = 32'h5555AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    k = 4;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("slow_rsp", rsp_valid, 1);
    chk("slow_lat", k, 8);
    chk("slow_rdata", rsp_rdata, 32'h11C011C0);
    exp_mc = sat(exp_mc);
    n_req++;
    repeat (4) @(negedge clk);
    chk("slow_one_rsp", rsp_pulses - p0, 1);
    chk("slow_miss_cnt", miss_cnt, exp_mc);
    chk("slow_hit_cnt", hit_cnt, exp_hc);
    mem_lat = 1;
    run_check("dropped", 0, 12'h0FF, 0, 32'h0FF0FF00,
              0, 0, 0, 0);

    // reset while a refill is outstanding
    mem_lat = 20;
    p0 = rsp_pulses;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 12'h2C5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_mv", mem_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_mem_valid", mem_valid, 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_req_ready", req_ready, 1);
    chk("rr_hit_cnt", hit_cnt, 0);
    chk("rr_miss_cnt", miss_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_hc = '0;
    exp_mc = '0;
    repeat (5) @(negedge clk);
    chk("rr_no_rsp", rsp_pulses - p0, 0);
    chk("rr_ready_after", req_ready, 1);
    mem_lat = 1;
    run_check("post_rst", 0, 12'h040, 0, 32'hAAAA5555,
              0, 0, 0, 0);

    // counters start near the top to reach saturation quickly
    @(negedge clk);
    force dut.hit_q = 16'hFFFC;
    @(negedge clk);
    release dut.hit_q;
    exp_hc = 16'hFFFC;
    for (int i = 0; i < 5; i++)
      run_check("sat_hit", 0, 12'h040, 0, 32'hAAAA5555,
                1, 0, 0, 0);
    chk("sat_hit_final", hit_cnt, 16'hFFFF);
    @(negedge clk);
    force dut.miss_q = 16'hFFFE;
    @(negedge clk);
    release dut.miss_q;
    exp_mc = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_check("sat_miss_a", 0, 12'h080, 0, 32'h80808080,
                0, 0, 0, 0);
      run_check("sat_miss_b", 0, 12'h040, 0, 32'hAAAA5555,
                0, 0, 0, 0);
    end
    chk("sat_miss_final", miss_cnt, 16'hFFFF);

    // random traffic on a few conflicting lines
    do_reset();
    spur = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ri = 6'($urandom_range(0, 3));
      rt = 6'($urandom_range(0, 3));
      a  = {rt, ri};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      mem_lat = $urandom_range(0, 3);
      h   = mval[ri] && (mres[ri] == a);
      wb  = !h && mval[ri] && mdirty[ri];
      wba = mres[ri];
      wbd = golden[wba];
      erd = we ? wd : golden[a];
      run_check("rnd", we, a, wd, erd, h, wb, wba, wbd);
      if (we) golden[a] = wd;
      if (!h) begin
        mres[ri] = a;
        mval[ri] = 1'b1;
        mdirty[ri] = 1'b0;
      end
      if (we) mdirty[ri] = 1'b1;
    end
    spur = 1'b0;

    repeat (3) @(negedge clk);
    chk("total_rsp", rsp_pulses, n_req);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
